// File: rtl/mac_stream_driver.sv
// Flow-controlled front end for a single-cycle systolic MAC element: operand FIFO,
// credit-gated issue, latency-matched tag pipeline and a result FIFO.
module mac_stream_driver #(
  parameter int DEPTH       = 4,
  parameter int MAC_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_data,
  input  logic [15:0] i_weight,
  input  logic [31:0] i_pre_result,
  output logic [15:0] o_mac_data,
  output logic [15:0] o_mac_weight,
  output logic [31:0] o_mac_pre_result,
  input  logic [15:0] i_mac_data_next,
  input  logic [15:0] i_mac_result,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [15:0] o_res,
  output logic [15:0] o_res_data_next,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + MAC_LATENCY + 2) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]      r_op_data   [DEPTH];
  logic [15:0]      r_op_weight [DEPTH];
  logic [31:0]      r_op_pre    [DEPTH];
  logic [AW-1:0]    r_op_wr, r_op_rd;
  logic [CW-1:0]    r_op_cnt;
  logic             r_op_full;

  logic [31:0]      r_res_mem [DEPTH];
  logic [AW-1:0]    r_res_wr, r_res_rd;
  logic [CW-1:0]    r_res_cnt;

  logic [MAC_LATENCY:0] r_tag;
  logic [15:0]      r_mac_data_p0;
  logic [15:0]      r_mac_weight_p0;
  logic [31:0]      r_mac_pre_p0;

  logic             w_op_push, w_issue, w_res_push, w_res_pop, w_res_valid;
  logic [CW-1:0]    w_op_cnt_nxt, w_inflight, w_used;
  logic [31:0]      w_res_head;

  // Credits: a result slot is reserved for every op from issue until it is read out.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= MAC_LATENCY; k++) begin
      w_inflight = w_inflight + CW'(r_tag[k]);
    end
    w_used = w_inflight + r_res_cnt;
  end

  assign w_op_push    = i_valid && !r_op_full;
  assign w_issue      = (r_op_cnt != '0) && (w_used < DEPTH_C);
  assign w_op_cnt_nxt = r_op_cnt + CW'(w_op_push) - CW'(w_issue);
  assign w_res_valid  = (r_res_cnt != '0);
  assign w_res_push   = r_tag[MAC_LATENCY];
  assign w_res_pop    = w_res_valid && i_res_ready;
  assign w_res_head   = r_res_mem[r_res_rd];

  // Operand FIFO
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_op_wr   <= '0;
      r_op_rd   <= '0;
      r_op_cnt  <= '0;
      r_op_full <= 1'b0;
    end else begin
      if (w_op_push) r_op_wr <= r_op_wr + AW'(1);
      if (w_issue)   r_op_rd <= r_op_rd + AW'(1);
      r_op_cnt  <= w_op_cnt_nxt;
      r_op_full <= (w_op_cnt_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_op_push) begin
      r_op_data[r_op_wr]   <= i_data;
      r_op_weight[r_op_wr] <= i_weight;
      r_op_pre[r_op_wr]    <= i_pre_result;
    end
  end

  // Issue stage (p0): drive the MAC, zero on idle cycles
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mac_data_p0   <= '0;
      r_mac_weight_p0 <= '0;
      r_mac_pre_p0    <= '0;
      r_tag           <= '0;
    end else begin
      if (w_issue) begin
        r_mac_data_p0   <= r_op_data[r_op_rd];
        r_mac_weight_p0 <= r_op_weight[r_op_rd];
        r_mac_pre_p0    <= r_op_pre[r_op_rd];
      end else begin
        r_mac_data_p0   <= '0;
        r_mac_weight_p0 <= '0;
        r_mac_pre_p0    <= '0;
      end
      r_tag <= {r_tag[MAC_LATENCY-1:0], w_issue};
    end
  end

  // Capture stage: result FIFO
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) r_res_wr <= r_res_wr + AW'(1);
      if (w_res_pop)  r_res_rd <= r_res_rd + AW'(1);
      r_res_cnt <= r_res_cnt + CW'(w_res_push) - CW'(w_res_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_res_push) r_res_mem[r_res_wr] <= {i_mac_result, i_mac_data_next};
  end

  assign o_ready          = !r_op_full;
  assign o_mac_data       = r_mac_data_p0;
  assign o_mac_weight     = r_mac_weight_p0;
  assign o_mac_pre_result = r_mac_pre_p0;
  assign o_res_valid      = w_res_valid;
  // Head is masked while empty so the stream reads zero after reset.
  assign o_res            = w_res_valid ? w_res_head[31:16] : 16'h0000;
  assign o_res_data_next  = w_res_valid ? w_res_head[15:0]  : 16'h0000;
  assign o_busy           = (r_op_cnt != '0) || (|r_tag) || w_res_valid;

endmodule
